ges_event_counter: RTL and testbench

- Sits between the I2C gesture reader and the display/beeper stages.
- Consumes the 8-bit gesture flag byte po_data (one-hot: 0x01 up, 0x02 down, 0x04 left, 0x08 right).
- Detects each new gesture and applies hold-off repeat rejection.
- Maintains a two-digit BCD counter (cnt_num = tens, cnt_unit = units) that drives the seven-segment display and beeper. Also emits a one-cycle event pulse and the latched gesture code.

---
 rtl/ges_event_counter.sv | 168 ++++++++++++++++
 tb/tb_ges_event_counter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ges_event_counter.sv
// Gesture event counter: turns the one-hot gesture flag byte from the I2C
// reader into single accepted events with hold-off repeat rejection, and
// keeps a two-digit BCD counter (tens/units) for the display and beeper.
module ges_event_counter #(
  parameter int unsigned HOLDOFF_CYC = 25_000_000,
  parameter int unsigned INIT_TENS   = 0,
  parameter int unsigned INIT_UNITS  = 0
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] po_data,
  input  logic       clr,
  output logic [3:0] cnt_num,
  output logic [3:0] cnt_unit,
  output logic [3:0] ges_code,
  output logic       evt_pulse,
  output logic       busy
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam logic [24:0] HOLD_LAST = 25'(HOLDOFF_CYC - 1);
  localparam logic [3:0]  INIT_T    = 4'(INIT_TENS);
  localparam logic [3:0]  INIT_U    = 4'(INIT_UNITS);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_ges_reg;
  logic [7:0]  r_ges_prev;
  logic [24:0] r_hold_cnt;
  logic [3:0]  r_tens;
  logic [3:0]  r_units;
  logic [3:0]  r_ges_code;
  logic        r_evt;
  logic        r_busy;

  logic        w_valid;
  logic        w_detect;
  logic        w_accept;
  logic        w_hold_done;
  logic [3:0]  w_tens_nxt;
  logic [3:0]  w_units_nxt;

  // Two-stage input pipeline: current and previous sampled gesture byte
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ges_reg  <= '0;
      r_ges_prev <= '0;
    end else begin
      r_ges_reg  <= po_data;
      r_ges_prev <= r_ges_reg;
    end
  end

  // A gesture is valid only when exactly one of the four low flags is set
  always_comb begin
    w_valid = 1'b0;
    case (r_ges_reg)
      8'h01, 8'h02, 8'h04, 8'h08: w_valid = 1'b1;
      default:                    w_valid = 1'b0;
    endcase
  end

  assign w_detect    = w_valid && (r_ges_reg != r_ges_prev);
  assign w_hold_done = (r_hold_cnt == HOLD_LAST);

  // FSM state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // FSM next state; detects while holding off are simply dropped
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_detect) begin
          w_state_nxt = S_HOLD;
          w_accept    = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_hold_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Hold-off counter, event strobe, latched gesture code and busy flag
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_hold_cnt <= '0;
      r_evt      <= 1'b0;
      r_ges_code <= '0;
      r_busy     <= 1'b0;
    end else if (w_accept) begin
      r_hold_cnt <= '0;
      r_evt      <= 1'b1;
      r_ges_code <= r_ges_reg[3:0];
      r_busy     <= 1'b1;
    end else begin
      r_evt <= 1'b0;
      if (r_state == S_HOLD) begin
        if (w_hold_done) begin
          r_hold_cnt <= '0;
          r_busy     <= 1'b0;
        end else begin
          r_hold_cnt <= r_hold_cnt + 25'd1;
        end
      end
    end
  end

  // BCD counter update; clr wins over an op but the event itself still stands
  always_comb begin
    w_tens_nxt  = r_tens;
    w_units_nxt = r_units;
    if (clr) begin
      w_tens_nxt  = INIT_T;
      w_units_nxt = INIT_U;
    end else if (w_accept) begin
      case (r_ges_reg[3:0])
        4'h1: begin
          if (r_units == 4'd9) begin
            w_units_nxt = 4'd0;
            w_tens_nxt  = (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
          end else begin
            w_units_nxt = r_units + 4'd1;
          end
        end
        4'h2: begin
          if (r_units == 4'd0) begin
            w_units_nxt = 4'd9;
            w_tens_nxt  = (r_tens == 4'd0) ? 4'd9 : r_tens - 4'd1;
          end else begin
            w_units_nxt = r_units - 4'd1;
          end
        end
        4'h4:    w_tens_nxt = (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
        4'h8:    w_tens_nxt = (r_tens == 4'd0) ? 4'd9 : r_tens - 4'd1;
        default: ;
      endcase
    end
  end

  // BCD digit registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_tens  <= INIT_T;
      r_units <= INIT_U;
    end else begin
      r_tens  <= w_tens_nxt;
      r_units <= w_units_nxt;
    end
  end

  assign cnt_num   = r_tens;
  assign cnt_unit  = r_units;
  assign ges_code  = r_ges_code;
  assign evt_pulse = r_evt;
  assign busy      = r_busy;

endmodule

// File: tb/tb_ges_event_counter.sv
// Bench for ges_event_counter with HOLDOFF_CYC=8 and zero initial digits.
// Stimulus pushes the hand-computed outcome of each gesture into a queue;
// a monitor pops one entry per evt_pulse and also checks pulse and busy widths.
module tb_ges_event_counter;

  localparam int unsigned HOLD = 8;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [7:0] po_data;
  logic       clr;
  logic [3:0] cnt_num;
  logic [3:0] cnt_unit;
  logic [3:0] ges_code;
  logic       evt_pulse;
  logic       busy;

  typedef struct {
    logic [3:0]  t;
    logic [3:0]  u;
    logic [3:0]  c;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  ges_event_counter #(
    .HOLDOFF_CYC(HOLD),
    .INIT_TENS  (0),
    .INIT_UNITS (0)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .po_data  (po_data),
    .clr      (clr),
    .cnt_num  (cnt_num),
    .cnt_unit (cnt_unit),
    .ges_code (ges_code),
    .evt_pulse(evt_pulse),
    .busy     (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one gesture from a 0x00 background, record its expected outcome
  task automatic ev(input logic [7:0] code, input logic [3:0] t, input logic [3:0] u,
                    input int unsigned hold);
    @(negedge sys_clk);
    po_data = code;
    q.push_back('{t: t, u: u, c: code[3:0], cyc: cyc + 2});
    repeat (hold) @(negedge sys_clk);
    po_data = 8'h00;
    repeat (2) @(negedge sys_clk);
  endtask

  // Monitor: scoreboard pop per event, pulse width and busy width checks
  initial begin : monitor
    exp_t        e;
    int unsigned bcnt;
    logic        prev_evt;
    bcnt     = 0;
    prev_evt = 1'b0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (!sys_rst_n) begin
        bcnt     = 0;
        prev_evt = 1'b0;
      end else begin
        if (prev_evt) chk("evt_width", int'(evt_pulse), 0);
        if (evt_pulse) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got evt_pulse cnt=%0d/%0d code=%0h expected no event (cycle %0d)",
                     cnt_num, cnt_unit, ges_code, cyc);
          end else begin
            e = q.pop_front();
            chk("ev_tens",    int'(cnt_num),  int'(e.t));
            chk("ev_units",   int'(cnt_unit), int'(e.u));
            chk("ev_code",    int'(ges_code), int'(e.c));
            chk("ev_latency", int'(cyc),      int'(e.cyc));
            chk("ev_busy",    int'(busy),     1);
          end
        end
        if (busy) bcnt++;
        else if (bcnt != 0) begin
          chk("busy_width", int'(bcnt), int'(HOLD));
          bcnt = 0;
        end
        prev_evt = evt_pulse;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    sys_rst_n = 1'b0;
    po_data   = 8'h00;
    clr       = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    chk("rst_tens",  int'(cnt_num),   0);
    chk("rst_units", int'(cnt_unit),  0);
    chk("rst_code",  int'(ges_code),  0);
    chk("rst_evt",   int'(evt_pulse), 0);
    chk("rst_busy",  int'(busy),      0);

    // Held gesture counts once
    ev(8'h01, 4'd0, 4'd1, 40);
    // Down wraps 00 -> 99, up wraps 99 -> 00
    ev(8'h02, 4'd0, 4'd0, 12);
    ev(8'h02, 4'd9, 4'd9, 12);
    repeat (8) @(negedge sys_clk);
    ev(8'h01, 4'd0, 4'd0, 12);
    // Preload 9/5, then tens-only wrap both ways
    ev(8'h02, 4'd9, 4'd9, 12);
    ev(8'h02, 4'd9, 4'd8, 12);
    ev(8'h02, 4'd9, 4'd7, 12);
    ev(8'h02, 4'd9, 4'd6, 12);
    ev(8'h02, 4'd9, 4'd5, 12);
    ev(8'h04, 4'd0, 4'd5, 12);
    ev(8'h08, 4'd9, 4'd5, 12);

    // Plain clr with no event
    @(negedge sys_clk);
    clr = 1'b1;
    @(negedge sys_clk);
    clr = 1'b0;
    chk("clr_tens",  int'(cnt_num),  0);
    chk("clr_units", int'(cnt_unit), 0);

    // Change inside hold-off is dropped; invalid codes ignored
    @(negedge sys_clk);
    po_data = 8'h01;
    q.push_back('{t: 4'd0, u: 4'd1, c: 4'h1, cyc: cyc + 2});
    repeat (3) @(negedge sys_clk);
    po_data = 8'h02;
    repeat (12) @(negedge sys_clk);
    po_data = 8'h03;
    repeat (5) @(negedge sys_clk);
    po_data = 8'h10;
    repeat (5) @(negedge sys_clk);
    po_data = 8'hFF;
    repeat (5) @(negedge sys_clk);
    po_data = 8'h00;
    repeat (3) @(negedge sys_clk);
    chk("drop_tens",  int'(cnt_num),  0);
    chk("drop_units", int'(cnt_unit), 1);

    // Walk to 4/7
    for (int i = 1; i <= 4; i++) ev(8'h04, 4'(i), 4'd1, 12);
    for (int i = 2; i <= 7; i++) ev(8'h01, 4'd4, 4'(i), 12);

    // clr coincident with an up event
    @(negedge sys_clk);
    po_data = 8'h01;
    q.push_back('{t: 4'd0, u: 4'd0, c: 4'h1, cyc: cyc + 2});
    @(negedge sys_clk);
    clr = 1'b1;
    @(negedge sys_clk);
    clr = 1'b0;
    chk("clrev_tens",  int'(cnt_num),   0);
    chk("clrev_units", int'(cnt_unit),  0);
    chk("clrev_evt",   int'(evt_pulse), 1);
    chk("clrev_busy",  int'(busy),      1);
    repeat (12) @(negedge sys_clk);
    po_data = 8'h00;
    repeat (2) @(negedge sys_clk);

    // Event to 0/1, then reset mid hold-off
    @(negedge sys_clk);
    po_data = 8'h01;
    q.push_back('{t: 4'd0, u: 4'd1, c: 4'h1, cyc: cyc + 2});
    repeat (4) @(negedge sys_clk);
    chk("pre_rst_busy", int'(busy), 1);
    sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_tens",  int'(cnt_num),   0);
    chk("mid_rst_units", int'(cnt_unit),  0);
    chk("mid_rst_code",  int'(ges_code),  0);
    chk("mid_rst_evt",   int'(evt_pulse), 0);
    chk("mid_rst_busy",  int'(busy),      0);
    repeat (2) @(negedge sys_clk);
    // po_data still 0x01: seen as a fresh change two edges after release
    sys_rst_n = 1'b1;
    q.push_back('{t: 4'd0, u: 4'd1, c: 4'h1, cyc: cyc + 2});
    repeat (14) @(negedge sys_clk);
    po_data = 8'h00;
    repeat (4) @(negedge sys_clk);

    chk("pending_events", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
